mfp_als_spi_sampler: RTL

Controller that sequences the PmodALS SPI pins (CS, SCK, SDO on JA) to read the ADC081S021 light sensor. It runs one 16-bit read frame on a software start pulse, or periodically while enabled. It extracts the 8-bit sample from each frame, flags malformed frames, and presents the result to the AHB-Lite GPIO side through a one-cycle valid strobe.

---
 rtl/mfp_als_spi_sampler_pkg.sv | 25 ++
 rtl/mfp_sync_2ff.sv | 23 ++
 rtl/mfp_als_spi_sampler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mfp_als_spi_sampler_pkg.sv
// Shared state encoding, ADC081S021 frame layout and default timing for the ALS sampler.
package mfp_als_spi_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE,
        ST_GAP
    } als_state_e;

    localparam int ALS_FRAME_BITS    = 16;
    localparam int ALS_DATA_MSB      = 12;
    localparam int ALS_DATA_LSB      = 5;
    localparam int DEF_CLK_DIV       = 8;
    localparam int DEF_SAMPLE_PERIOD = 50000;

    // The ADC pads its 8-bit result with zeros on both sides; anything else is a broken frame.
    function automatic logic als_frame_bad(input logic [ALS_FRAME_BITS-1:0] frame);
        return (frame[ALS_FRAME_BITS-1:ALS_DATA_MSB+1] != '0) ||
               (frame[ALS_DATA_LSB-1:0] != '0);
    endfunction

endpackage

// File: rtl/mfp_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous inputs; width is a parameter.
module mfp_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mfp_als_spi_sampler.sv
// PmodALS read controller: runs 16-bit SPI frames on start or a periodic tick and
// publishes the 8-bit light sample with a one-cycle valid strobe.
module mfp_als_spi_sampler
    import mfp_als_spi_sampler_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       start,
    input  logic       spi_sdo,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PER_W = $clog2(SAMPLE_PERIOD);

    als_state_e                state;
    logic [DIV_W-1:0]          div_cnt;
    logic [3:0]                bit_cnt;
    logic [ALS_FRAME_BITS-1:0] shreg;
    logic [PER_W-1:0]          period_cnt;
    logic                      pending;
    logic [0:0]                sdo_sync;
    logic                      tick;
    logic                      trigger;
    logic                      div_last;

    mfp_sync_2ff #(.WIDTH(1)) u_sdo_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (spi_sdo),
        .q      (sdo_sync)
    );

    assign tick     = enable && (period_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign trigger  = start || tick;
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
        end else if (!enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            pending      <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_sck      <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // Only one request can wait behind a running frame; later ones are absorbed.
            if (state == ST_IDLE)
                pending <= 1'b0;
            else if (trigger)
                pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (trigger || pending) begin
                        state    <= ST_SETUP;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (div_last) begin
                        state   <= ST_SHIFT;
                        spi_sck <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            shreg   <= {shreg[ALS_FRAME_BITS-2:0], sdo_sync};
                        end else if (bit_cnt == 4'd15) begin
                            state <= ST_HOLD;
                        end else begin
                            spi_sck <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_last) begin
                        state        <= ST_DONE;
                        spi_cs_n     <= 1'b1;
                        sample_valid <= 1'b1;
                        frame_err    <= als_frame_bad(shreg);
                        if (!als_frame_bad(shreg))
                            sample <= shreg[ALS_DATA_MSB:ALS_DATA_LSB];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_GAP;
                    div_cnt <= '0;
                end
                // DONE plus GAP keep CS high for CLK_DIV quiet cycles before IDLE.
                ST_GAP: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 2)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
